// File: rtl/pdpu_pkg.sv
// ============================================================================
// Module      : pdpu_pkg
// Description : Shared types and helpers for the PDPU datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } csa_res_state_e;

    function automatic int unsigned csa_num_chunks(input int unsigned width,
                                                   input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-chunk resolver still needs a 1-bit index register.
    function automatic int unsigned csa_idx_width(input int unsigned width,
                                                  input int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pdpu_pkg

`default_nettype wire

// File: rtl/csa_resolver_seq_cpa_chunk.sv
// ============================================================================
// Module      : fulladder / cpa_chunk
// Description : Ripple carry-propagate adder slice used by csa_resolver_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule : fulladder

module cpa_chunk #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = i_ci;
    assign o_co   = w_c[WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        fulladder u_fa (
            .i_a  (i_a[g]),
            .i_b  (i_b[g]),
            .i_ci (w_c[g]),
            .o_s  (o_s[g]),
            .o_co (w_c[g+1])
        );
    end
endmodule : cpa_chunk

`default_nettype wire

// File: rtl/csa_resolver_seq.sv
// ============================================================================
// Module      : csa_resolver_seq
// Description : Sequential CHUNK-bit-per-cycle resolver of a carry-save pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_resolver_seq
    import pdpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o
);
    localparam int unsigned NUM_CHUNKS = csa_num_chunks(WIDTH, CHUNK);
    localparam int unsigned IDXW       = csa_idx_width(WIDTH, CHUNK);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NUM_CHUNKS - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolver_seq: WIDTH must be a multiple of CHUNK");
    end

    csa_res_state_e   r_state;
    csa_res_state_e   w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_cy;
    logic [IDXW-1:0]  r_idx;

    logic [CHUNK-1:0] w_op_a;
    logic [CHUNK-1:0] w_op_b;
    logic [CHUNK-1:0] w_chunk_s;
    logic             w_chunk_co;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Flush overrides everything, including a handshake in this cycle.
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
        end
    end

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            if (r_idx == IDXW'(k)) begin
                w_op_a = r_sum[k*CHUNK +: CHUNK];
                w_op_b = r_carry[k*CHUNK +: CHUNK];
            end
        end
    end

    cpa_chunk #(
        .WIDTH (CHUNK)
    ) u_cpa_chunk (
        .i_a  (w_op_a),
        .i_b  (w_op_b),
        .i_ci (r_cy),
        .o_s  (w_chunk_s),
        .o_co (w_chunk_co)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum    <= '0;
            r_carry  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_cy     <= 1'b0;
            r_idx    <= '0;
        end else if (flush_i) begin
            r_idx <= '0;
            r_cy  <= 1'b0;
        end else if (w_accept) begin
            r_sum   <= sum_i;
            r_carry <= carry_i;
            r_idx   <= '0;
            r_cy    <= 1'b0;
        end else if (r_state == BUSY) begin
            for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
                if (r_idx == IDXW'(k)) begin
                    r_result[k*CHUNK +: CHUNK] <= w_chunk_s;
                end
            end
            r_cy <= w_chunk_co;
            if (r_idx == c_last_idx) begin
                r_idx  <= '0;
                r_cout <= w_chunk_co;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign result_o = r_result;
    assign cout_o   = r_cout;

endmodule : csa_resolver_seq

`default_nettype wire
